// File: rtl/multi_shot_control_pkg.sv
// Shared screen geometry and default bounds for the paddle laser shot logic.
package multi_shot_control_pkg;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_TOP   = 0;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
endpackage

// File: rtl/shot_slot.sv
// One laser shot slot: load on fire, climb SPEED px per tick, retire at top or on hit.
// Latency 1 cycle from load/hit to active change; no backpressure.
module shot_slot
  import multi_shot_control_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TOP   = DEF_TOP,
  parameter int SPEED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  input  logic             hit,
  input  logic             tick,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             active
);
  // One extra bit so TOP+SPEED near the top of the range cannot wrap.
  localparam logic [WIDTH:0] MIN_Y = (WIDTH+1)'(TOP + SPEED);

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (hit && active) begin
      active <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      x      <= load_x;
      y      <= load_y;
    end else if (tick && active) begin
      if ({1'b0, y} < MIN_Y)
        active <= 1'b0;
      else
        y <= y - WIDTH'(SPEED);
    end
  end
endmodule

// File: rtl/multi_shot_control.sv
// Multi-slot laser shot controller: edge-detected fire into the lowest free slot, cooldown, step divider.
// Latency 1 cycle from rising shot to active/fired; refused requests pulse dropped, never queued.
module multi_shot_control
  import multi_shot_control_pkg::*;
#(
  parameter int N_SHOTS  = 4,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TOP      = DEF_TOP,
  parameter int SPEED    = 1,
  parameter int STEP_DIV = 1,
  parameter int COOLDOWN = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     shot,
  input  logic [WIDTH-1:0]         in_x,
  input  logic [WIDTH-1:0]         in_y,
  input  logic [N_SHOTS-1:0]       hit,
  output logic [N_SHOTS*WIDTH-1:0] x,
  output logic [N_SHOTS*WIDTH-1:0] y,
  output logic [N_SHOTS-1:0]       active,
  output logic                     fired,
  output logic                     dropped
);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [WIDTH:0] MIN_Y = (WIDTH+1)'(TOP + SPEED);

  logic               shot_prev;
  logic [DW-1:0]      div;
  logic [CW-1:0]      cool;
  logic               rise;
  logic               tick;
  logic               accept;
  logic               found;
  logic [N_SHOTS-1:0] load_sel;

  // Lowest-index free slot; a slot being hit this cycle is still active, so not free.
  always_comb begin
    load_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < N_SHOTS; i++) begin
      if (!active[i] && !found) begin
        load_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign rise   = shot & ~shot_prev;
  assign tick   = (div == DW'(STEP_DIV - 1));
  assign accept = rise && (cool == '0) && found && ({1'b0, in_y} >= MIN_Y);

  always_ff @(posedge clock) begin
    if (reset) begin
      shot_prev <= 1'b0;
      div       <= '0;
      cool      <= '0;
      fired     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      shot_prev <= shot;
      div       <= tick ? '0 : div + 1'b1;
      if (accept)
        cool <= CW'(COOLDOWN);
      else if (cool != '0)
        cool <= cool - 1'b1;
      fired   <= accept;
      dropped <= rise && !accept;
    end
  end

  for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
    shot_slot #(
      .WIDTH(WIDTH),
      .TOP  (TOP),
      .SPEED(SPEED)
    ) u_slot (
      .clock (clock),
      .reset (reset),
      .load  (accept && load_sel[g]),
      .load_x(in_x),
      .load_y(in_y),
      .hit   (hit[g]),
      .tick  (tick),
      .x     (x[g*WIDTH +: WIDTH]),
      .y     (y[g*WIDTH +: WIDTH]),
      .active(active[g])
    );
  end
endmodule
